// File: rtl/digit_entry_ctrl.sv
// digit_entry_ctrl: turns keypad events into shift/clear strobes for an external
// digit shift register and tracks digit count and decimal-point position.
//
// Handshakes:
//   key:     a key is taken on a rising edge where key_valid && key_ready; when
//            key_ready is low the key is simply dropped (producer must re-present).
//   operand: op_valid rises on enter and stays high with op_dp_pos stable until
//            an edge where op_valid && op_ready; the operand is consumed there.
module digit_entry_ctrl #(
  parameter int COUNT = 4,
  parameter int WIDTH = 4,
  localparam int CW = $clog2(COUNT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic             key_ready,
  output logic             sr_trig,
  output logic             sr_reset,
  output logic             sr_dir,
  output logic [WIDTH-1:0] sr_in,
  output logic [CW-1:0]    digit_count,
  output logic             dp_seen,
  output logic [CW-1:0]    dp_pos,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [CW-1:0]    op_dp_pos,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_CLEAR = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [CW-1:0] COUNT_C = CW'(COUNT);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  state_e           state_q, state_d;
  logic [CW-1:0]    digit_count_q, digit_count_d;
  logic             dp_seen_q, dp_seen_d;
  logic [CW-1:0]    dp_pos_q, dp_pos_d;
  logic             sr_trig_q, sr_trig_d;
  logic             sr_reset_q, sr_reset_d;
  logic             sr_dir_q, sr_dir_d;
  logic [WIDTH-1:0] sr_in_q, sr_in_d;
  logic             op_valid_q, op_valid_d;
  logic [CW-1:0]    op_dp_pos_q, op_dp_pos_d;
  logic             key_take;

  // The clear strobe after reset also blocks keys so the shift register is
  // empty before the first digit arrives.
  assign key_ready = (state_q == S_IDLE) && !sr_reset_q;
  assign key_take  = key_valid && key_ready;

  // Next-state and next-output logic; strobes default low, data holds.
  always_comb begin
    state_d       = state_q;
    digit_count_d = digit_count_q;
    dp_seen_d     = dp_seen_q;
    dp_pos_d      = dp_pos_q;
    sr_trig_d     = 1'b0;
    sr_reset_d    = 1'b0;
    sr_dir_d      = sr_dir_q;
    sr_in_d       = sr_in_q;
    op_valid_d    = op_valid_q;
    op_dp_pos_d   = op_dp_pos_q;
    unique case (state_q)
      S_IDLE: begin
        if (key_take) begin
          if (key_code <= 4'd9) begin
            // Full register: the digit is swallowed.
            if (digit_count_q < COUNT_C) begin
              sr_dir_d = 1'b0;
              sr_in_d  = WIDTH'(key_code);
              state_d  = S_SHIFT;
            end
          end else if (key_code == 4'hA) begin
            dp_seen_d = 1'b1;
          end else if (key_code == 4'hB) begin
            // A bare trailing point is removed before any digit.
            if (dp_seen_q && (dp_pos_q == '0)) begin
              dp_seen_d = 1'b0;
            end else if (digit_count_q != '0) begin
              sr_dir_d = 1'b1;
              sr_in_d  = '0;
              state_d  = S_SHIFT;
            end
          end else if (key_code == 4'hC) begin
            sr_reset_d    = 1'b1;
            digit_count_d = '0;
            dp_seen_d     = 1'b0;
            dp_pos_d      = '0;
            state_d       = S_CLEAR;
          end else if (key_code == 4'hD) begin
            op_dp_pos_d = dp_seen_q ? dp_pos_q : '0;
            op_valid_d  = 1'b1;
            state_d     = S_DONE;
          end
        end
      end
      S_SHIFT: begin
        // dir/in were set on entry, so they are stable before and during trig.
        sr_trig_d = 1'b1;
        state_d   = S_IDLE;
        if (!sr_dir_q) begin
          digit_count_d = digit_count_q + ONE_C;
          if (dp_seen_q) dp_pos_d = dp_pos_q + ONE_C;
        end else begin
          digit_count_d = digit_count_q - ONE_C;
          if (dp_seen_q) dp_pos_d = dp_pos_q - ONE_C;
        end
      end
      S_CLEAR: begin
        state_d = S_IDLE;
      end
      S_DONE: begin
        if (op_ready) begin
          op_valid_d    = 1'b0;
          sr_reset_d    = 1'b1;
          digit_count_d = '0;
          dp_seen_d     = 1'b0;
          dp_pos_d      = '0;
          state_d       = S_CLEAR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts everything and schedules a clear strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      digit_count_q <= '0;
      dp_seen_q     <= 1'b0;
      dp_pos_q      <= '0;
      sr_trig_q     <= 1'b0;
      sr_reset_q    <= 1'b1;
      sr_dir_q      <= 1'b0;
      sr_in_q       <= '0;
      op_valid_q    <= 1'b0;
      op_dp_pos_q   <= '0;
    end else begin
      state_q       <= state_d;
      digit_count_q <= digit_count_d;
      dp_seen_q     <= dp_seen_d;
      dp_pos_q      <= dp_pos_d;
      sr_trig_q     <= sr_trig_d;
      sr_reset_q    <= sr_reset_d;
      sr_dir_q      <= sr_dir_d;
      sr_in_q       <= sr_in_d;
      op_valid_q    <= op_valid_d;
      op_dp_pos_q   <= op_dp_pos_d;
    end
  end

  assign sr_trig     = sr_trig_q;
  assign sr_reset    = sr_reset_q;
  assign sr_dir      = sr_dir_q;
  assign sr_in       = sr_in_q;
  assign digit_count = digit_count_q;
  assign dp_seen     = dp_seen_q;
  assign dp_pos      = dp_pos_q;
  assign op_valid    = op_valid_q;
  assign op_dp_pos   = op_dp_pos_q;
  assign dbg_state   = state_q;

endmodule
